// File: rtl/sr_flag_bank_pkg.sv
// rtl/sr_flag_bank_pkg.sv - shared types and next-state helper for the set/reset flag bank
package sr_flag_bank_pkg;

  localparam int N_CH_MAX = 32;

  typedef enum logic [1:0] {
    CF_SET_WINS = 2'd0,
    CF_CLR_WINS = 2'd1,
    CF_HOLD     = 2'd2,
    CF_TOGGLE   = 2'd3
  } conflict_e;

  // Resolves one channel's next flag value; the policy only matters when set and clear collide.
  function automatic logic resolve_next(conflict_e cf, logic set_eff, logic clr, logic q);
    logic r;
    case ({set_eff, clr})
      2'b00:   r = q;
      2'b10:   r = 1'b1;
      2'b01:   r = 1'b0;
      default: begin
        case (cf)
          CF_SET_WINS: r = 1'b1;
          CF_CLR_WINS: r = 1'b0;
          CF_HOLD:     r = q;
          default:     r = ~q;
        endcase
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sr_flag_bank_if.sv
// rtl/sr_flag_bank_if.sv - request/status bundle between a flag bank and its user
interface sr_flag_bank_if #(
  parameter int N_CH = 8
);

  logic [N_CH-1:0] set_i;
  logic [N_CH-1:0] clr_i;
  logic [N_CH-1:0] mask_i;
  logic [N_CH-1:0] q_o;
  logic [N_CH-1:0] q_n_o;
  logic [N_CH-1:0] rise_o;
  logic [N_CH-1:0] ovf_o;
  logic            irq_o;

  modport master (
    output set_i, clr_i, mask_i,
    input  q_o, q_n_o, rise_o, ovf_o, irq_o
  );

  modport slave (
    input  set_i, clr_i, mask_i,
    output q_o, q_n_o, rise_o, ovf_o, irq_o
  );

endinterface

// File: rtl/sr_flag_bank_cell.sv
// rtl/sr_flag_bank_cell.sv - one flag channel: set qualification, state, rise pulse, overflow
module sr_flag_cell
  import sr_flag_bank_pkg::*;
#(
  parameter conflict_e CONFLICT = CF_SET_WINS,
  parameter bit        EDGE_SET = 1'b0,
  parameter bit        RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic set_i,
  input  logic clr_i,
  output logic q_o,
  output logic q_n_o,
  output logic rise_o,
  output logic ovf_o,
  output logic q_next_o
);

  logic set_prev_q;
  logic q_q;
  logic q_n_q;
  logic rise_q;
  logic ovf_q;

  logic set_eff;
  logic q_d;
  logic rise_d;
  logic ovf_d;

  always_comb begin
    set_eff = EDGE_SET ? (set_i & ~set_prev_q) : set_i;
    q_d     = resolve_next(CONFLICT, set_eff, clr_i, q_q);
    rise_d  = q_d & ~q_q;
    // A clear always wins over overflow capture, whatever the flag conflict policy.
    ovf_d   = ~clr_i & (ovf_q | (set_eff & q_q));
  end

  // set_prev resets high so a set held through reset release is not taken as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_prev_q <= 1'b1;
      q_q        <= RST_VAL;
      q_n_q      <= ~RST_VAL;
      rise_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      set_prev_q <= set_i;
      q_q        <= q_d;
      q_n_q      <= ~q_d;
      rise_q     <= rise_d;
      ovf_q      <= ovf_d;
    end
  end

  assign q_o      = q_q;
  assign q_n_o    = q_n_q;
  assign rise_o   = rise_q;
  assign ovf_o    = ovf_q;
  assign q_next_o = q_d;

endmodule

// File: rtl/sr_flag_bank.sv
// rtl/sr_flag_bank.sv - N_CH independent set/reset flags with a masked, registered interrupt
module sr_flag_bank
  import sr_flag_bank_pkg::*;
#(
  parameter int              N_CH     = 8,
  parameter int              CONFLICT = 0,
  parameter bit              EDGE_SET = 1'b0,
  parameter logic [N_CH-1:0] RST_VAL  = '0
) (
  input logic                clk,
  input logic                rst,
  sr_flag_bank_if.slave      bus
);

  localparam conflict_e CF = conflict_e'(CONFLICT[1:0]);

  logic [N_CH-1:0] q_w;
  logic [N_CH-1:0] q_n_w;
  logic [N_CH-1:0] rise_w;
  logic [N_CH-1:0] ovf_w;
  logic [N_CH-1:0] q_next_w;

  logic irq_q;
  logic irq_d;

  for (genvar g = 0; g < N_CH; g++) begin : g_cell
    sr_flag_cell #(
      .CONFLICT (CF),
      .EDGE_SET (EDGE_SET),
      .RST_VAL  (RST_VAL[g])
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .set_i    (bus.set_i[g]),
      .clr_i    (bus.clr_i[g]),
      .q_o      (q_w[g]),
      .q_n_o    (q_n_w[g]),
      .rise_o   (rise_w[g]),
      .ovf_o    (ovf_w[g]),
      .q_next_o (q_next_w[g])
    );
  end

  // Built from the next flag state so irq_o moves on the same edge as q_o.
  always_comb begin
    irq_d = |(q_next_w & bus.mask_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign bus.q_o    = q_w;
  assign bus.q_n_o  = q_n_w;
  assign bus.rise_o = rise_w;
  assign bus.ovf_o  = ovf_w;
  assign bus.irq_o  = irq_q;

endmodule

// File: tb/tb_sr_flag_bank.sv
// tb/tb_sr_flag_bank.sv - directed checks of sr_flag_bank across edge and conflict configurations
module tb_sr_flag_bank;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [7:0] e_set, e_clr, e_mask;
  logic [7:0] c_set, c_clr, c_mask;

  sr_flag_bank_if #(.N_CH(8)) if_e  ();
  sr_flag_bank_if #(.N_CH(8)) if_c0 ();
  sr_flag_bank_if #(.N_CH(8)) if_c1 ();
  sr_flag_bank_if #(.N_CH(8)) if_c2 ();
  sr_flag_bank_if #(.N_CH(8)) if_c3 ();

  assign if_e.set_i   = e_set;
  assign if_e.clr_i   = e_clr;
  assign if_e.mask_i  = e_mask;
  assign if_c0.set_i  = c_set;
  assign if_c0.clr_i  = c_clr;
  assign if_c0.mask_i = c_mask;
  assign if_c1.set_i  = c_set;
  assign if_c1.clr_i  = c_clr;
  assign if_c1.mask_i = c_mask;
  assign if_c2.set_i  = c_set;
  assign if_c2.clr_i  = c_clr;
  assign if_c2.mask_i = c_mask;
  assign if_c3.set_i  = c_set;
  assign if_c3.clr_i  = c_clr;
  assign if_c3.mask_i = c_mask;

  sr_flag_bank #(.N_CH(8), .CONFLICT(0), .EDGE_SET(1'b1), .RST_VAL(8'hA5)) u_e
    (.clk(clk), .rst(rst), .bus(if_e));
  sr_flag_bank #(.N_CH(8), .CONFLICT(0), .EDGE_SET(1'b0), .RST_VAL(8'h00)) u_c0
    (.clk(clk), .rst(rst), .bus(if_c0));
  sr_flag_bank #(.N_CH(8), .CONFLICT(1), .EDGE_SET(1'b0), .RST_VAL(8'h00)) u_c1
    (.clk(clk), .rst(rst), .bus(if_c1));
  sr_flag_bank #(.N_CH(8), .CONFLICT(2), .EDGE_SET(1'b0), .RST_VAL(8'h00)) u_c2
    (.clk(clk), .rst(rst), .bus(if_c2));
  sr_flag_bank #(.N_CH(8), .CONFLICT(3), .EDGE_SET(1'b0), .RST_VAL(8'h00)) u_c3
    (.clk(clk), .rst(rst), .bus(if_c3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    e_set    = 8'hFF;
    e_clr    = 8'h00;
    e_mask   = 8'hFF;
    c_set    = 8'h00;
    c_clr    = 8'h00;
    c_mask   = 8'h00;

    // reset state with set held high through release
    repeat (2) @(posedge clk);
    #2;
    check("rst_e_q",    32'(if_e.q_o),    32'hA5);
    check("rst_e_qn",   32'(if_e.q_n_o),  32'h5A);
    check("rst_e_ovf",  32'(if_e.ovf_o),  32'h00);
    check("rst_e_rise", 32'(if_e.rise_o), 32'h00);
    check("rst_e_irq",  32'(if_e.irq_o),  32'h0);
    check("rst_c0_q",   32'(if_c0.q_o),   32'h00);
    check("rst_c0_qn",  32'(if_c0.q_n_o), 32'hFF);
    rst = 1'b0;
    #1;
    check("rel_e_irq0", 32'(if_e.irq_o),  32'h0);
    step();
    check("rel_e_irq1", 32'(if_e.irq_o),  32'h1);
    check("rel_e_q",    32'(if_e.q_o),    32'hA5);
    check("rel_e_ovf",  32'(if_e.ovf_o),  32'h00);
    step();
    check("hold_e_q",   32'(if_e.q_o),    32'hA5);
    check("hold_e_rise", 32'(if_e.rise_o), 32'h00);

    // edge qualification: single set per rising edge, clear during hold sticks
    e_set = 8'h00;
    step();
    e_set = 8'h02;
    step();
    check("edge_q",     32'(if_e.q_o),    32'hA7);
    check("edge_rise",  32'(if_e.rise_o), 32'h02);
    step();
    step();
    check("edge_hold_q",   32'(if_e.q_o),    32'hA7);
    check("edge_hold_ovf", 32'(if_e.ovf_o),  32'h00);
    check("edge_hold_rise", 32'(if_e.rise_o), 32'h00);
    e_clr = 8'h02;
    step();
    check("edge_clr_q", 32'(if_e.q_o),    32'hA5);
    e_clr = 8'h00;
    step();
    check("edge_noredo_q", 32'(if_e.q_o), 32'hA5);
    e_set = 8'h00;
    step();
    e_set = 8'h03;
    step();
    check("edge_reset_q",  32'(if_e.q_o),   32'hA7);
    check("edge_ovf",      32'(if_e.ovf_o), 32'h01);
    check("edge_qn",       32'(if_e.q_n_o), 32'h58);

    // basic SR
    c_set = 8'h01;
    step();
    check("sr_c0_q",    32'(if_c0.q_o),    32'h01);
    check("sr_c0_rise", 32'(if_c0.rise_o), 32'h01);
    check("sr_c0_qn",   32'(if_c0.q_n_o),  32'hFE);
    check("sr_c0_irq",  32'(if_c0.irq_o),  32'h0);
    c_set = 8'h00;
    step();
    check("sr_c0_q_hold",    32'(if_c0.q_o),    32'h01);
    check("sr_c0_rise_gone", 32'(if_c0.rise_o), 32'h00);
    c_clr = 8'h01;
    step();
    check("sr_c0_clr", 32'(if_c0.q_o), 32'h00);
    c_set = 8'h01;
    step();
    check("both_c0", 32'(if_c0.q_o), 32'h01);
    check("both_c1", 32'(if_c1.q_o), 32'h00);
    check("both_c2", 32'(if_c2.q_o), 32'h00);
    check("both_c3", 32'(if_c3.q_o), 32'h01);
    c_set = 8'h00;
    step();
    check("clr_c3", 32'(if_c3.q_o), 32'h00);
    c_clr = 8'h00;

    // conflict sweep on ch3 starting from q=1
    c_set = 8'h08;
    step();
    check("pre_c1", 32'(if_c1.q_o), 32'h08);
    c_clr = 8'h08;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("cf_c0_%0d", i), 32'(if_c0.q_o), 32'h08);
      check($sformatf("cf_c0ovf_%0d", i), 32'(if_c0.ovf_o), 32'h00);
      check($sformatf("cf_c1_%0d", i), 32'(if_c1.q_o), 32'h00);
      check($sformatf("cf_c2_%0d", i), 32'(if_c2.q_o), 32'h08);
      check($sformatf("cf_c3_%0d", i), 32'(if_c3.q_o), (i == 1) ? 32'h08 : 32'h00);
      check($sformatf("cf_c3rise_%0d", i), 32'(if_c3.rise_o), (i == 1) ? 32'h08 : 32'h00);
    end
    c_set = 8'h00;
    c_clr = 8'hFF;
    step();
    check("clrall_c2", 32'(if_c2.q_o), 32'h00);
    c_clr = 8'h00;

    // overflow on ch5
    c_set = 8'h20;
    step();
    check("ovf_q1",    32'(if_c0.q_o),   32'h20);
    check("ovf_1",     32'(if_c0.ovf_o), 32'h00);
    step();
    check("ovf_2",     32'(if_c0.ovf_o), 32'h20);
    c_set = 8'h00;
    step();
    check("ovf_sticky", 32'(if_c0.ovf_o), 32'h20);
    c_clr = 8'h20;
    step();
    check("ovf_clr_q", 32'(if_c0.q_o),   32'h00);
    check("ovf_clr",   32'(if_c0.ovf_o), 32'h00);
    c_clr = 8'h00;

    // interrupt masking
    c_set = 8'h12;
    step();
    check("irq_q12",   32'(if_c0.q_o),   32'h12);
    check("irq_mask0", 32'(if_c0.irq_o), 32'h0);
    c_set  = 8'h00;
    c_mask = 8'h01;
    step();
    check("irq_mask01", 32'(if_c0.irq_o), 32'h0);
    c_mask = 8'h02;
    #1;
    check("irq_mask_lag", 32'(if_c0.irq_o), 32'h0);
    step();
    check("irq_mask02", 32'(if_c0.irq_o), 32'h1);

    // burst then asynchronous reset mid-cycle
    c_set = 8'hFF;
    step();
    check("burst_q",    32'(if_c0.q_o),    32'hFF);
    check("burst_rise", 32'(if_c0.rise_o), 32'hED);
    check("burst_ovf",  32'(if_c0.ovf_o),  32'h12);
    rst = 1'b1;
    #1;
    check("arst_c0_q",    32'(if_c0.q_o),    32'h00);
    check("arst_c0_qn",   32'(if_c0.q_n_o),  32'hFF);
    check("arst_c0_rise", 32'(if_c0.rise_o), 32'h00);
    check("arst_c0_ovf",  32'(if_c0.ovf_o),  32'h00);
    check("arst_c0_irq",  32'(if_c0.irq_o),  32'h0);
    check("arst_e_q",     32'(if_e.q_o),     32'hA5);
    check("arst_e_ovf",   32'(if_e.ovf_o),   32'h00);
    c_set = 8'h00;
    step();
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
